// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix C unloader and its index counter.
package matrix_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter width for n states, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Linear element position of (row, col) in a row-major flat matrix
    function automatic int unsigned elem_index(input int unsigned r,
                                               input int unsigned c,
                                               input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// Row/column walker for the unloader; reports the element index after the next advance
// and whether the current position is the final one. MATRIX_C_TRANSPOSE_EN walks column-major.
module matrix_idx_counter
    import matrix_pkg::*;
#(
    parameter int unsigned ROW    = 4,
    parameter int unsigned COLUMN = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           enable,
    output logic [cnt_w(ROW*COLUMN)-1:0]   next_index_c,
    output logic                           last_c
);

    localparam int unsigned RW = cnt_w(ROW);
    localparam int unsigned CW = cnt_w(COLUMN);
    localparam int unsigned IW = cnt_w(ROW * COLUMN);
    localparam logic [RW-1:0] R_MAX = RW'(ROW - 1);
    localparam logic [CW-1:0] C_MAX = CW'(COLUMN - 1);

    logic [RW-1:0] r, r_nxt;
    logic [CW-1:0] c, c_nxt;

    // Position after one advance; the fast counter wraps and carries into the slow one
    always_comb begin
        r_nxt = r;
        c_nxt = c;
`ifdef MATRIX_C_TRANSPOSE_EN
        r_nxt = (r == R_MAX) ? '0 : r + RW'(1);
        if (r == R_MAX)
            c_nxt = (c == C_MAX) ? '0 : c + CW'(1);
`else
        c_nxt = (c == C_MAX) ? '0 : c + CW'(1);
        if (c == C_MAX)
            r_nxt = (r == R_MAX) ? '0 : r + RW'(1);
`endif
    end

    assign last_c       = (r == R_MAX) && (c == C_MAX);
    assign next_index_c = IW'(elem_index(32'(r_nxt), 32'(c_nxt), COLUMN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r <= '0;
            c <= '0;
        end else if (clear) begin
            r <= '0;
            c <= '0;
        end else if (enable) begin
            r <= r_nxt;
            c <= c_nxt;
        end
    end

endmodule

// File: rtl/matrix_c_unloader.sv
// Snapshots a flat ROWxCOLUMN matrix on C_opcode and streams it one word per valid/ready transfer.
// Define MATRIX_C_TRANSPOSE_EN for column-major output order.
module matrix_c_unloader
    import matrix_pkg::*;
#(
    parameter int unsigned ROW    = 4,
    parameter int unsigned COLUMN = 4,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         C_opcode,
    input  logic [ROW*COLUMN*DATA_W-1:0] Data_in,
    input  logic                         Ready_C,
    output logic [DATA_W-1:0]            Data_from_C,
    output logic                         Valid_C,
    output logic                         Busy_C,
    output logic                         Done_C
);

    localparam int unsigned N  = ROW * COLUMN;
    localparam int unsigned IW = cnt_w(N);

    state_t            state;
    logic [DATA_W-1:0] snap [N];
    logic [IW-1:0]     next_idx_c;
    logic              last_c;
    logic              start_c;
    logic              xfer_c;

    assign start_c = (state == IDLE) && C_opcode;
    assign xfer_c  = (state == STREAM) && Valid_C && Ready_C;

    matrix_idx_counter #(
        .ROW    (ROW),
        .COLUMN (COLUMN)
    ) u_idx (
        .clk          (clk),
        .reset        (reset),
        .clear        (start_c),
        .enable       (xfer_c),
        .next_index_c (next_idx_c),
        .last_c       (last_c)
    );

    // FSM, snapshot and registered output word; element 0 leads in either order
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            Valid_C     <= 1'b0;
            Busy_C      <= 1'b0;
            Done_C      <= 1'b0;
            Data_from_C <= '0;
            for (int k = 0; k < int'(N); k++)
                snap[k] <= '0;
        end else begin
            Done_C <= 1'b0;
            case (state)
                IDLE: begin
                    if (C_opcode) begin
                        for (int k = 0; k < int'(N); k++)
                            snap[k] <= Data_in[k*DATA_W +: DATA_W];
                        Data_from_C <= Data_in[DATA_W-1:0];
                        Valid_C     <= 1'b1;
                        Busy_C      <= 1'b1;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer_c) begin
                        if (last_c) begin
                            Data_from_C <= '0;
                            Valid_C     <= 1'b0;
                            Busy_C      <= 1'b0;
                            Done_C      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            Data_from_C <= snap[next_idx_c];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    Valid_C     <= 1'b0;
                    Busy_C      <= 1'b0;
                    Data_from_C <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_c_unloader.sv
// Scoreboard bench for matrix_c_unloader: expected words queued at start, popped by a monitor per transfer.
module tb_matrix_c_unloader;

    localparam int unsigned ROW    = 4;
    localparam int unsigned COLUMN = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned N      = ROW * COLUMN;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    C_opcode;
    logic [N*DATA_W-1:0]     Data_in;
    logic                    Ready_C;
    logic [DATA_W-1:0]       Data_from_C;
    logic                    Valid_C;
    logic                    Busy_C;
    logic                    Done_C;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [DATA_W-1:0] exp_q [$];
    int unsigned xfers = 0;
    int unsigned dones = 0;

    always #5 clk = ~clk;

    matrix_c_unloader #(.ROW(ROW), .COLUMN(COLUMN), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .C_opcode    (C_opcode),
        .Data_in     (Data_in),
        .Ready_C     (Ready_C),
        .Data_from_C (Data_from_C),
        .Valid_C     (Valid_C),
        .Busy_C      (Busy_C),
        .Done_C      (Done_C)
    );

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Stream order model: element k of the flat matrix holds 0x100+k
    function automatic logic [DATA_W-1:0] exp_word(input int unsigned k);
`ifdef MATRIX_C_TRANSPOSE_EN
        return DATA_W'(32'h100 + (k % ROW) * COLUMN + k / ROW);
`else
        return DATA_W'(32'h100 + k);
`endif
    endfunction

    task automatic load_pattern();
        for (int k = 0; k < int'(N); k++)
            Data_in[k*DATA_W +: DATA_W] = DATA_W'(32'h100 + k);
    endtask

    task automatic push_expected();
        for (int k = 0; k < int'(N); k++)
            exp_q.push_back(exp_word(k));
    endtask

    task automatic do_start();
        @(posedge clk); #1 C_opcode = 1'b1;
        @(posedge clk); #1 C_opcode = 1'b0;
        check("start_valid", 32'(Valid_C), 32'd1);
        check("start_busy",  32'(Busy_C),  32'd1);
    endtask

    task automatic wait_done(input string name);
        int unsigned seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (Done_C) seen = 1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({name, "_done_1cyc"}, 32'(Done_C), 32'd0);
        check({name, "_busy_low"},  32'(Busy_C), 32'd0);
    endtask

    // Monitor: pops one expected word per transfer, checks stall stability and idle outputs
    logic              stalled = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            if (stalled)
                check("stall_hold", Data_from_C, stall_data);
            stalled = Valid_C && !Ready_C;
            stall_data = Data_from_C;
            if (!Valid_C && Data_from_C !== '0)
                check("idle_data_zero", Data_from_C, '0);
            if (Busy_C !== Valid_C)
                check("busy_eq_valid", 32'(Busy_C), 32'(Valid_C));
            if (Valid_C && Ready_C) begin
                xfers++;
                if (exp_q.size() == 0)
                    check("unexpected_xfer", Data_from_C, '0);
                else
                    check("stream_word", Data_from_C, exp_q.pop_front());
            end
            if (Done_C) begin
                dones++;
                check("done_q_empty", 32'(exp_q.size()), 32'd0);
                check("done_valid_low", 32'(Valid_C), 32'd0);
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        int unsigned stall_cnt;
        int unsigned found;
        reset = 1'b0; C_opcode = 1'b0; Ready_C = 1'b1; Data_in = '0;
        load_pattern();
        #1;
        check("rst_valid", 32'(Valid_C), 32'd0);
        check("rst_busy",  32'(Busy_C),  32'd0);
        check("rst_done",  32'(Done_C),  32'd0);
        check("rst_data",  Data_from_C,  '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_no_valid", 32'(Valid_C), 32'd0);

        // Full stream with Ready_C held high
        xfers = 0; dones = 0;
        push_expected();
        do_start();
        check("first_word", Data_from_C, exp_word(0));
        wait_done("t2");
        check("t2_xfers", 32'(xfers), 32'(N));
        check("t2_dones", 32'(dones), 32'd1);

        // Three stall cycles while 0x105 is presented
        xfers = 0; stall_cnt = 0;
        push_expected();
        do_start();
        for (int i = 0; i < 60 && Valid_C; i++) begin
            if (Data_from_C == 32'h105 && stall_cnt < 3) begin
                Ready_C = 1'b0;
                stall_cnt++;
            end else begin
                Ready_C = 1'b1;
            end
            @(posedge clk); #1;
        end
        Ready_C = 1'b1;
        check("t3_stalls", 32'(stall_cnt), 32'd3);
        wait_done("t3");
        check("t3_xfers", 32'(xfers), 32'(N));

        // Data_in change and a new C_opcode mid-stream must not disturb the snapshot
        xfers = 0;
        push_expected();
        do_start();
        @(posedge clk); #1;
        Data_in = '1;
        C_opcode = 1'b1;
        @(posedge clk); #1 C_opcode = 1'b0;
        wait_done("t4");
        check("t4_xfers", 32'(xfers), 32'(N));
        repeat (4) @(posedge clk);
        #1 check("t4_no_restart", 32'(Valid_C), 32'd0);
        load_pattern();

        // Reset while 0x107 is presented, then a clean restart from 0x100
        push_expected();
        do_start();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (Valid_C && Data_from_C == 32'h107) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("t5_reached_107", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(Valid_C), 32'd0);
        check("t5_rst_busy",  32'(Busy_C),  32'd0);
        check("t5_rst_data",  Data_from_C,  '0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("t5_no_valid", 32'(Valid_C), 32'd0);
        xfers = 0;
        push_expected();
        do_start();
        check("t5_restart_word", Data_from_C, exp_word(0));
        wait_done("t5");
        check("t5_xfers", 32'(xfers), 32'(N));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
